alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for any value 2..64.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  WIDTH  operand A, sampled on accept.
REQ-005 b  input  WIDTH  operand B, sampled on accept.
REQ-006 select  input  4  opcode, sampled on accept.
REQ-007 in_valid  input  1  request present; in_ready  output  1  block can accept.
REQ-008 out  output  WIDTH  registered result.
REQ-009 carry  output  1  registered carry/borrow/overflow bit.
REQ-010 flag  output  1  registered zero flag: 1 when out is all zeros.
REQ-011 out_valid  output  1  result present; out_ready  input  1  consumer takes result.

Function
REQ-012 Accept SHALL occur on a rising edge with in_valid && in_ready; a, b and select SHALL be captured then and ignored afterwards.
REQ-013 The FSM SHALL have three states: IDLE, MUL and DONE; in_ready SHALL be 1 only in IDLE, combinationally.
REQ-014 IDLE transitions: accept with select=1001 (when multiply is compiled in) SHALL go to MUL; any other accept SHALL go to DONE with the result registered on the same edge.
REQ-015 DONE SHALL drive out_valid=1; out, carry and flag SHALL hold stable until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-016 Latency SHALL be: single-cycle ops, out_valid high on the edge after accept; multiply, out_valid high WIDTH+1 edges after accept.
REQ-017 Opcodes SHALL be: 0000 a+b; 0001 a-b; 0010 a&b; 0011 a|b; 0100 a^b; 0101 ~a; 0110 a<<1; 0111 a>>1 (logical); 1000 unsigned a<b ? 1 : 0; 1001 a*b low WIDTH bits.
REQ-018 Any other opcode SHALL give out=0, carry=0, flag=1.
REQ-019 carry SHALL be:
- add: bit WIDTH of the WIDTH+1-bit sum.
- sub: borrow, i.e. a<b unsigned.
- shl: a[WIDTH-1]; shr: a[0].
- mul: 1 if the upper WIDTH bits of the 2*WIDTH product are nonzero.
- all other ops: 0.
REQ-020 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-021 flag SHALL be derived from the registered result value, never from an intermediate.
REQ-022 Multiply SHALL be iterative shift-add, one bit of b per cycle over WIDTH cycles, with no combinational WIDTH x WIDTH multiplier.
REQ-023 in_valid asserted outside IDLE SHALL have no effect; no request is queued.

Reset
REQ-024 While rst=1 at an edge:
- state SHALL become IDLE.
- out=0, carry=0, flag=0, out_valid=0.
- in_ready SHALL read 1 in the cycle after reset.
REQ-025 rst SHALL take priority over accept and out_ready on the same edge.
REQ-026 Reset during MUL or DONE SHALL abort the operation and discard its result.

Configuration
REQ-027 Macro ALU_MC_MUL_EN defined: opcode 1001 and the MUL state SHALL be built per REQ-014/016/022.
REQ-028 Macro ALU_MC_MUL_EN undefined: no multiplier logic SHALL exist, and opcode 1001 SHALL behave per REQ-018 with single-cycle latency.

Structure
REQ-029 Package alu_mc_pkg SHALL hold:
- opcode constants for 0000..1001;
- FSM state typedef (IDLE, MUL, DONE).
REQ-030 The multiplier SHALL be sub-module alu_mul_iter, instantiated only under ALU_MC_MUL_EN, with ports:
- clk, rst, start, a, b;
- done, product (2*WIDTH bits).

Verification
REQ-031 WIDTH=8, add a=200 b=100, out_ready=1 -> out=44, carry=1, flag=0, out_valid one edge after accept.
REQ-032 Sub a=5 b=5 -> out=0, flag=1, carry=0. Sub a=3 b=5 -> out=254, carry=1.
REQ-033 Or a=0x0F b=0xF0, then out_ready held low 3 cycles while in_valid stays high with new operands -> out=0xFF held, in_ready=0, second request accepted only after the out_ready handshake.
REQ-034 ALU_MC_MUL_EN defined, mul a=20 b=15 -> out=44, carry=1, out_valid 9 edges after accept. Without the macro -> out=0, flag=1 after 1 edge.
REQ-035 rst pulsed mid-multiply -> out_valid=0, out=0, in_ready=1 next cycle, then a fresh add 1+1 returns 2.
REQ-036 WIDTH=16, shl a=0x8001 -> out=0x0002, carry=1. Opcode 1111 -> out=0, flag=1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared opcodes and FSM encoding for the multi-cycle ALU.
// The multiplier path is built only when ALU_MC_MUL_EN is defined.
package alu_mc_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b0111;
   localparam logic [3:0] OP_LT  = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b1001;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_MUL  = 2'd1;
   localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one bit of b per cycle, done pulses
// one cycle after the last iteration with the full 2*WIDTH product.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
         end else if (busy) begin
            if (mplier[0])
               acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; ALU_MC_MUL_EN adds
// the iterative multiply opcode (1001) and the MUL state.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       select,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             flag,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t             state;
   logic               accept;
   logic               go_mul;
   logic               mul_done;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   res;
   logic               cy;
   logic [WIDTH:0]     sum;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;
   assign sum       = {1'b0, a} + {1'b0, b};

`ifdef ALU_MC_MUL_EN
   assign go_mul = (select == OP_MUL);

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && go_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );
`else
   assign go_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign product  = '0;
`endif

   always_comb begin
      res = '0;
      cy  = 1'b0;
      unique case (select)
         OP_ADD: begin
            res = sum[WIDTH-1:0];
            cy  = sum[WIDTH];
         end
         OP_SUB: begin
            res = a - b;
            cy  = (a < b);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = ~a;
         OP_SHL: begin
            res = a << 1;
            cy  = a[WIDTH-1];
         end
         OP_SHR: begin
            res = a >> 1;
            cy  = a[0];
         end
         OP_LT:  res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: begin
            res = '0;
            cy  = 1'b0;
         end
      endcase
   end

   // flag is computed from exactly the value being latched into out
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         out   <= '0;
         carry <= 1'b0;
         flag  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (go_mul) begin
                     state <= S_MUL;
                  end else begin
                     state <= S_DONE;
                     out   <= res;
                     carry <= cy;
                     flag  <= ~|res;
                  end
               end
            end
            S_MUL: begin
               if (mul_done) begin
                  state <= S_DONE;
                  out   <= product[WIDTH-1:0];
                  carry <= |product[2*WIDTH-1:WIDTH];
                  flag  <= ~|product[WIDTH-1:0];
               end
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and random checks of alu_mc (WIDTH=8) against an
// arithmetic reference model.
module tb_alu_mc;

   localparam int W = 8;
   localparam int M = 256;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   select = '0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic [W-1:0] out;
   logic         carry;
   logic         flag;
   logic         out_valid;

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   alu_mc #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .select    (select),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .carry     (carry),
      .flag      (flag),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      ntot++;
      assert (got === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // returns {carry, out}
   function automatic logic [W:0] model(int op, int x, int y);
      int r;
      int c;
      r = 0;
      c = 0;
      case (op)
         0: begin r = x + y; c = int'(r >= M); r = r % M; end
         1: begin c = int'(x < y); r = (x - y + M) % M; end
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = M - 1 - x;
         6: begin c = int'(x >= M / 2); r = (2 * x) % M; end
         7: begin c = x % 2; r = x / 2; end
         8: r = int'(x < y);
`ifdef ALU_MC_MUL_EN
         9: begin c = int'(x * y >= M); r = (x * y) % M; end
`endif
         default: r = 0;
      endcase
      return {c[0], r[W-1:0]};
   endfunction

   function automatic int lat_of(int op);
`ifdef ALU_MC_MUL_EN
      if (op == 9) return W + 1;
`endif
      return 1;
   endfunction

   task automatic run(input int op, input int x, input int y,
                      input string tag);
      logic [W:0] e;
      int lat;
      e = model(op, x, y);
      @(negedge clk);
      select    = op[3:0];
      a         = x[W-1:0];
      b         = y[W-1:0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk({tag, ".rdy"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ".lat"}, lat, lat_of(op));
      chk({tag, ".out"}, out, e[W-1:0]);
      chk({tag, ".carry"}, carry, e[W]);
      chk({tag, ".flag"}, flag, (e[W-1:0] == 0));
      @(posedge clk);
      #1;
      chk({tag, ".drain"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out", out, 0);
      chk("rst.carry", carry, 0);
      chk("rst.flag", flag, 0);
      chk("rst.ovalid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst.iready", in_ready, 1);

      run(0, 200, 100, "add");
      chk("add.44", out, 44);
      run(1, 5, 5, "sub0");
      chk("sub0.flag", flag, 1);
      run(1, 3, 5, "subb");
      chk("subb.254", out, 254);
      run(9, 20, 15, "mul");
      run(6, 8'h81, 0, "shl");
      chk("shl.2", out, 2);
      run(7, 8'h81, 0, "shr");
      run(8, 3, 7, "lt");
      run(5, 8'hFF, 0, "not");
      run(15, 9, 9, "op15");
      chk("op15.flag", flag, 1);

      // backpressure: result must hold, new request must wait
      @(negedge clk);
      select    = 4'd3;
      a         = 8'h0F;
      b         = 8'hF0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      select = 4'd2;
      a      = 8'h3C;
      b      = 8'h0F;
      repeat (3) begin
         chk("bp.ovalid", out_valid, 1);
         chk("bp.out", out, 8'hFF);
         chk("bp.iready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.idle", in_ready, 1);
      chk("bp.idle.ov", out_valid, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp.second.ov", out_valid, 1);
      chk("bp.second.out", out, 8'h0C);
      @(posedge clk);
      #1;

      // reset in the middle of an operation
      @(negedge clk);
      select    = 4'd9;
      a         = 8'd20;
      b         = 8'd15;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst.ovalid", out_valid, 0);
      chk("mrst.out", out, 0);
      chk("mrst.iready", in_ready, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("mrst.quiet", out_valid, 0);
      run(0, 1, 1, "post");
      chk("post.2", out, 2);

      for (int i = 0; i < 40; i++)
         run(int'($urandom_range(0, 15)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)), "rnd");

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
